// File: rtl/router_reg_p.sv
// Router datapath register block: header/hold/output registers, running packet
// check (XOR parity or additive checksum), payload length check and error flags.
module router_reg_p #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned CHK_MODE = 0,
  parameter int unsigned LEN_CHK  = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              parity_err,
  output logic              len_err
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_chk;
  logic [DATA_W-1:0] r_pkt_chk;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              r_parity_err;
  logic              r_len_err;
  logic              r_err;

  logic              w_hdr_ld;
  logic              w_fold_pl;
  logic              w_chk_cap;
  logic [DATA_W-1:0] w_fold_in;
  logic [DATA_W-1:0] w_chk_nxt;
  logic [LEN_W-1:0]  w_hdr_len;
  logic              w_par_mis;
  logic              w_len_mis;

  // An all-ones address is not a routable destination, so the header is ignored.
  assign w_hdr_ld  = detect_add & pkt_valid & (data_in[ADDR_W-1:0] != {ADDR_W{1'b1}});
  assign w_fold_pl = ld_state & pkt_valid & ~full_state;
  assign w_chk_cap = (ld_state & ~fifo_full & ~pkt_valid)
                   | (laf_state & r_low_pkt_valid & ~r_parity_done);
  assign w_fold_in = lfd_state ? r_hdr : data_in;
  assign w_hdr_len = r_hdr[DATA_W-1:ADDR_W];
  assign w_par_mis = (r_chk != r_pkt_chk);
  assign w_len_mis = (LEN_CHK != 0) && (r_cnt != w_hdr_len);

  always_comb begin
    w_chk_nxt = r_chk;
    if (CHK_MODE == 0) w_chk_nxt = r_chk ^ w_fold_in;
    else               w_chk_nxt = r_chk + w_fold_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       r_hdr <= '0;
    else if (w_hdr_ld) r_hdr <= data_in;
  end

  // Output word mux; a word blocked by a full FIFO is parked in r_hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dout <= '0;
      r_hold <= '0;
    end else begin
      if (lfd_state)                   r_dout <= r_hdr;
      else if (ld_state && !fifo_full) r_dout <= data_in;
      else if (laf_state)              r_dout <= r_hold;
      if (ld_state && fifo_full)       r_hold <= data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_chk <= '0;
      r_cnt <= '0;
    end else if (detect_add) begin
      r_chk <= '0;
      r_cnt <= '0;
    end else if (lfd_state) begin
      r_chk <= w_chk_nxt;
    end else if (w_fold_pl) begin
      r_chk <= w_chk_nxt;
      if (r_cnt != {LEN_W{1'b1}}) r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_chk     <= '0;
      r_parity_done <= 1'b0;
    end else if (detect_add) begin
      r_parity_done <= 1'b0;
    end else if (w_chk_cap) begin
      r_pkt_chk     <= data_in;
      r_parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                       r_low_pkt_valid <= 1'b0;
    else if (rst_int_reg)              r_low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)   r_low_pkt_valid <= 1'b1;
  end

  // Errors are judged the cycle after the check word lands and stay sticky.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_parity_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_err        <= 1'b0;
    end else if (detect_add) begin
      r_parity_err <= 1'b0;
      r_len_err    <= 1'b0;
      r_err        <= 1'b0;
    end else if (r_parity_done) begin
      r_parity_err <= r_parity_err | w_par_mis;
      r_len_err    <= r_len_err | w_len_mis;
      r_err        <= r_err | w_par_mis | w_len_mis;
    end
  end

  assign dout          = r_dout;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;
  assign parity_err    = r_parity_err;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_router_reg_p.sv
// Scoreboard bench for router_reg_p: an 8-bit XOR-parity instance and a
// 16-bit checksum instance share stimulus; a monitor checks FIFO writes and errors.
`timescale 1ns/1ps
module tb_router_reg_p;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        detect_add = 1'b0;
  logic        lfd_state = 1'b0;
  logic        ld_state = 1'b0;
  logic        laf_state = 1'b0;
  logic        full_state = 1'b0;
  logic        rst_int_reg = 1'b0;
  logic [15:0] d = 16'h0000;

  logic [7:0]  dout8;
  logic        pd8, lpv8, err8, perr8, lerr8;
  logic [15:0] dout16;
  logic        pd16, lpv16, err16, perr16, lerr16;

  always #5 clock = ~clock;

  router_reg_p #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0), .LEN_CHK(1)) u_dut8 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(d[7:0]),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout8), .parity_done(pd8),
    .low_pkt_valid(lpv8), .err(err8), .parity_err(perr8), .len_err(lerr8)
  );

  router_reg_p #(.DATA_W(16), .ADDR_W(2), .CHK_MODE(1), .LEN_CHK(1)) u_dut16 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(d),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout16), .parity_done(pd16),
    .low_pkt_valid(lpv16), .err(err16), .parity_err(perr16), .len_err(lerr16)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sel16 = 1'b0;
  logic [15:0] exp_dout_q[$];
  logic [2:0]  exp_err_q[$];
  logic [15:0] pl [0:15];

  // Selected instance view: {parity_done, parity_err, len_err, err, low_pkt_valid}
  logic [15:0] w_dout;
  logic [4:0]  w_flags;
  assign w_dout  = sel16 ? dout16 : {8'h00, dout8};
  assign w_flags = sel16 ? {pd16, perr16, lerr16, err16, lpv16}
                         : {pd8, perr8, lerr8, err8, lpv8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a FIFO write happens the cycle after lfd, ld&!full or laf.
  logic wr_q = 1'b0;
  bit   pd_prev = 1'b0;
  bit   pd_arm = 1'b0;
  always @(posedge clock)
    wr_q <= resetn && (lfd_state || (ld_state && !fifo_full) || laf_state);

  always @(negedge clock) begin
    if (wr_q) begin
      if (exp_dout_q.size() == 0) chk("dout_unexpected_write", 32'(w_dout), 32'hFFFF_FFFF);
      else                        chk("dout", 32'(w_dout), 32'(exp_dout_q.pop_front()));
    end
    if (pd_arm) begin
      pd_arm = 1'b0;
      if (exp_err_q.size() == 0) chk("err_unexpected", 32'(w_flags[3:1]), 32'hFFFF_FFFF);
      else                       chk("perr_lerr_err", 32'(w_flags[3:1]), 32'(exp_err_q.pop_front()));
    end
    if (w_flags[4] && !pd_prev && resetn) pd_arm = 1'b1;
    pd_prev = w_flags[4];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
    full_state = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input int n, input logic [15:0] chkw,
                          input int full_idx, input logic [2:0] exp_e);
    idle_in(); detect_add = 1'b1; pkt_valid = 1'b1; d = hdr; step();
    chk("clear_on_detect", 32'(w_flags[4:1]), 32'h0);
    idle_in(); lfd_state = 1'b1; pkt_valid = 1'b1; d = hdr;
    exp_dout_q.push_back(hdr); step();
    for (int i = 0; i < n; i++) begin
      idle_in(); ld_state = 1'b1; pkt_valid = 1'b1; d = pl[i];
      if (i == full_idx) begin
        fifo_full = 1'b1; step();
        idle_in(); full_state = 1'b1; pkt_valid = 1'b1; d = 16'h00EE; step();
        idle_in(); laf_state = 1'b1; pkt_valid = 1'b1; d = 16'h00EE;
      end
      exp_dout_q.push_back(pl[i]); step();
    end
    idle_in(); ld_state = 1'b1; d = chkw;
    exp_dout_q.push_back(chkw); exp_err_q.push_back(exp_e); step();
    chk("done_and_lowpv_set", 32'({w_flags[4], w_flags[0]}), 32'h3);
    idle_in(); step();
    idle_in(); rst_int_reg = 1'b1; step();
    chk("lowpv_cleared", 32'(w_flags[0]), 32'h0);
    idle_in(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in(); resetn = 1'b0; d = 16'h0000;
    step(); step();
    chk("reset8", 32'({dout8, pd8, lpv8, err8, perr8, lerr8}), 32'h0);
    chk("reset16", 32'({dout16, pd16, lpv16, err16, perr16, lerr16}), 32'h0);
    resetn = 1'b1; step();

    // Header 0x22: len 8, correct parity 0xAA
    pl[0] = 16'h11; pl[1] = 16'h22; pl[2] = 16'h33; pl[3] = 16'h44;
    pl[4] = 16'h55; pl[5] = 16'h66; pl[6] = 16'h77; pl[7] = 16'h88;
    send_pkt(16'h0022, 8, 16'h00AA, -1, 3'b000);
    // Same packet, inverted parity word
    send_pkt(16'h0022, 8, 16'h0055, -1, 3'b101);
    chk("err_sticky", 32'(w_flags[3:1]), 32'h5);
    // Zero-length header 0x02: check covers header only
    send_pkt(16'h0002, 0, 16'h0002, -1, 3'b000);
    // fifo_full on payload word 3 (0xA5), parity 0x47
    pl[0] = 16'h10; pl[1] = 16'h20; pl[2] = 16'h30; pl[3] = 16'hA5;
    pl[4] = 16'h50; pl[5] = 16'h60; pl[6] = 16'h70; pl[7] = 16'h80;
    send_pkt(16'h0022, 8, 16'h0047, 3, 3'b000);
    // Header 0x12 claims len 4, 5 words sent, parity 0xF3
    pl[0] = 16'hA1; pl[1] = 16'hB2; pl[2] = 16'hC3; pl[3] = 16'hD4; pl[4] = 16'hE5;
    send_pkt(16'h0012, 5, 16'h00F3, -1, 3'b011);

    // Address 3 header is ignored: lfd replays previous header 0x12
    idle_in(); detect_add = 1'b1; pkt_valid = 1'b1; d = 16'h0023; step();
    idle_in(); lfd_state = 1'b1; pkt_valid = 1'b1; d = 16'h0023;
    exp_dout_q.push_back(16'h0012); step();
    idle_in(); ld_state = 1'b1; pkt_valid = 1'b1; d = 16'h005A;
    exp_dout_q.push_back(16'h005A); step();
    idle_in(); ld_state = 1'b1; pkt_valid = 1'b1; d = 16'h003C;
    exp_dout_q.push_back(16'h003C); step();
    @(negedge clock); #1;
    idle_in(); resetn = 1'b0; #1;
    chk("reset_async_mid_pkt", 32'({dout8, pd8, lpv8, err8, perr8, lerr8}), 32'h0);
    step(); step();
    resetn = 1'b1;
    step(); step(); step();
    chk("no_err_after_reset", 32'({dout8, pd8, lpv8, err8, perr8, lerr8}), 32'h0);

    // 16-bit checksum instance: 0x0010 + 4*0xFFFF = 0x000C
    sel16 = 1'b1;
    pl[0] = 16'hFFFF; pl[1] = 16'hFFFF; pl[2] = 16'hFFFF; pl[3] = 16'hFFFF;
    send_pkt(16'h0010, 4, 16'h000C, -1, 3'b000);
    send_pkt(16'h0010, 4, 16'h000D, -1, 3'b101);

    idle_in(); step(); step();
    chk("dout_queue_drained", 32'(exp_dout_q.size()), 32'h0);
    chk("err_queue_drained", 32'(exp_err_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_reg_p.md
ROUTER_REG_P -- requirements
Module: router_reg_p

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; legal range 8..32.
REQ-002 Parameter ADDR_W, default 2, header address field width (header[ADDR_W-1:0]); length field LEN_W = DATA_W-ADDR_W (header[DATA_W-1:ADDR_W]).
REQ-003 Parameter CHK_MODE, default 0, check mode: 0 = XOR parity, 1 = modulo-2^DATA_W additive checksum.
REQ-004 Parameter LEN_CHK, default 1, enables payload-length checking when 1; when 0, len_err is tied to 0.
REQ-005 clock  in  1  single system clock, all state updated on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 pkt_valid  in  1  packet data valid from source.
REQ-008 data_in  in  DATA_W  header/payload/check word from source.
REQ-009 fifo_full  in  1  selected output FIFO full.
REQ-010 detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  one-hot FSM state indications from the router controller.
REQ-011 rst_int_reg  in  1  clears low_pkt_valid.
REQ-012 dout  out  DATA_W  word to FIFO.
REQ-013 parity_done  out  1  check word captured.
REQ-014 low_pkt_valid  out  1  pkt_valid fell during ld_state.
REQ-015 err  out  1  any packet error (parity_err | len_err).
REQ-016 parity_err, len_err  out  1 each  error cause flags.

Function
REQ-017 Header capture: when detect_add & pkt_valid & header address != all-ones, data_in SHALL be latched into hdr_reg; all-ones address SHALL leave hdr_reg unchanged.
REQ-018 dout SHALL update one cycle after the qualifying state: lfd_state -> hdr_reg; ld_state & !fifo_full -> data_in; laf_state -> hold_reg; otherwise dout holds.
REQ-019 ld_state & fifo_full SHALL latch data_in into hold_reg; dout holds.
REQ-020 Running check: cleared to 0 on detect_add; lfd_state folds hdr_reg; ld_state & pkt_valid & !full_state folds data_in; fold = XOR (CHK_MODE 0) or add truncated to DATA_W (CHK_MODE 1).
REQ-021 Payload counter (LEN_W bits, saturating at all-ones): cleared on detect_add, incremented on same condition as payload fold in REQ-020.
REQ-022 Check-word capture: pkt_chk latched from data_in when (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done); same cycle sets parity_done.
REQ-023 parity_done SHALL clear on detect_add; capture of REQ-022 has priority only if detect_add is low.
REQ-024 low_pkt_valid SHALL set on ld_state & !pkt_valid, clear on rst_int_reg; rst_int_reg wins if simultaneous.
REQ-025 One cycle after parity_done is high: parity_err = (running check != pkt_chk); len_err = LEN_CHK & (counter != hdr_reg length field); err = parity_err | len_err.
REQ-026 parity_err, len_err, err SHALL stay set until the next detect_add, which clears them.
REQ-027 Zero-length header: counter compared against 0; check covers header only.
REQ-028 Wrong-length packets SHALL still complete normally (no stall); only len_err reports it.

Reset
REQ-029 resetn low SHALL asynchronously clear dout, hdr_reg, hold_reg, running check, pkt_chk, counter, parity_done, low_pkt_valid, parity_err, len_err, err to 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release no error flag SHALL be raised for it.

Verification
REQ-031 DATA_W=8, CHK_MODE 0: header 8'h22 (len 8, addr 2), 8 random payload words, correct XOR parity, fifo_full=0 -> dout streams 8'h22 then payload one cycle late, parity_done=1 after parity word, err=0 next cycle.
REQ-032 Same packet with inverted parity word -> parity_err=1, err=1, len_err=0; next detect_add clears both.
REQ-033 Header 8'h12 (len 4) with 5 payload words, correct parity -> len_err=1, err=1, parity_err=0.
REQ-034 fifo_full=1 during payload word 3 (value 8'hA5) then laf_state -> dout=8'hA5 in cycle after laf_state; parity still correct, err=0.
REQ-035 Header 8'h23 (addr 3) under detect_add -> hdr_reg unchanged; resetn pulsed low mid-payload -> all outputs 0 immediately, no err after release.
REQ-036 DATA_W=16, CHK_MODE 1: header 16'h0010 (len 4), payload 16'hFFFF x4, checksum 16'h000C -> err=0; checksum 16'h000D -> parity_err=1.
